// File: rtl/fifo_arbiter_rr.sv
// N-channel entry merger: per-channel slot buffers feed one OUT_W FIFO write port,
// sending each BEATS-word entry contiguously under round-robin or fixed priority.

module fifo_arb_slot #(
    parameter int IN_W       = 480,
    parameter int SLOT_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] wdata,
    input  logic            push,
    input  logic            pop,
    output logic [IN_W-1:0] head,
    output logic            full,
    output logic            nonempty,
    output logic            single,
    output logic            overflow
);
    localparam int PW   = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;
    localparam int CNTW = $clog2(SLOT_DEPTH + 1);

    logic [IN_W-1:0] mem [SLOT_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            wr_en;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(SLOT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // full comes from the registered count, so a push racing a pop is still dropped
    assign full     = (count == CNTW'(SLOT_DEPTH));
    assign nonempty = (count != '0);
    assign single   = (count == CNTW'(1));
    assign wr_en    = push & ~full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)   rd_ptr <= wrap_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            if (push && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end
endmodule

module fifo_arbiter_rr #(
    parameter  int NUM_CH     = 2,
    parameter  int OUT_W      = 240,
    parameter  int BEATS      = 2,
    parameter  int SLOT_DEPTH = 2,
    parameter  int RR_MODE    = 1,
    localparam int IN_W       = OUT_W * BEATS,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*IN_W-1:0] in_data,
    input  logic [NUM_CH-1:0]      in_push,
    output logic [NUM_CH-1:0]      in_full,
    output logic [NUM_CH-1:0]      overflow,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_push,
    output logic                   out_last,
    output logic [CW-1:0]          out_ch,
    input  logic                   out_full,
    output logic                   busy
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic             push;
        logic             last;
        logic [CW-1:0]    ch;
        logic [OUT_W-1:0] data;
    } beat_t;

    state_t                       state, state_n;
    logic [CW-1:0]                grant, grant_n, rr_ptr, rr_n;
    logic [BW-1:0]                beat, beat_n;
    beat_t                        out_q, out_n;
    logic [NUM_CH-1:0]            req, single, pop, req_rearb;
    logic [NUM_CH-1:0][IN_W-1:0]  head;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_arb_slot #(.IN_W(IN_W), .SLOT_DEPTH(SLOT_DEPTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wdata    (in_data[c*IN_W +: IN_W]),
            .push     (in_push[c]),
            .pop      (pop[c]),
            .head     (head[c]),
            .full     (in_full[c]),
            .nonempty (req[c]),
            .single   (single[c]),
            .overflow (overflow[c])
        );
    end

    function automatic logic [CW-1:0] arb(input logic [NUM_CH-1:0] r, input logic [CW-1:0] p);
        logic [CW-1:0] sel;
        logic          found;
        int            j;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = (RR_MODE != 0) ? (int'(p) + i) % NUM_CH : i;
            if (!found && r[j]) begin
                sel   = CW'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        beat_n    = beat;
        rr_n      = rr_ptr;
        pop       = '0;
        req_rearb = req;
        out_n      = out_q;
        out_n.push = 1'b0;
        out_n.last = 1'b0;
        case (state)
            IDLE: begin
                if (|req && !out_full) begin
                    grant_n = arb(req, rr_ptr);
                    beat_n  = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (!out_full) begin
                    out_n.push = 1'b1;
                    out_n.ch   = grant;
                    out_n.data = head[grant][int'(beat)*OUT_W +: OUT_W];
                    out_n.last = (beat == BW'(BEATS - 1));
                    if (out_n.last) begin
                        pop[grant] = 1'b1;
                        if (RR_MODE != 0)
                            rr_n = (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
                        // re-arbitrate as if the popped entry were already gone
                        req_rearb[grant] = ~single[grant];
                        if (|req_rearb) begin
                            grant_n = arb(req_rearb, rr_n);
                            beat_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        beat_n = beat + BW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            beat   <= '0;
            rr_ptr <= '0;
            out_q  <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            beat   <= beat_n;
            rr_ptr <= rr_n;
            out_q  <= out_n;
        end
    end

    assign out_push = out_q.push;
    assign out_last = out_q.last;
    assign out_ch   = out_q.ch;
    assign out_data = out_q.data;
    assign busy     = (|req) | (state == SEND);
endmodule
